// File: rtl/median_pkg.sv
// median_pkg: shared types and sizing for the sequential 3x3 median engine
//   state_t : LOAD, COMP, DROP, OUT
//   pix_t   : 8-bit pixel
//   NPIX/NCMP/NPASS : pixels per frame, compares per pass, passes per frame
package median_pkg;
    typedef logic [7:0] pix_t;
    typedef enum logic [1:0] {LOAD, COMP, DROP, OUT} state_t;
    localparam logic [3:0] NPIX  = 4'd9;
    localparam logic [3:0] NCMP  = 4'd8;
    localparam logic [2:0] NPASS = 3'd5;
endpackage

// File: rtl/median_seq_mce.sv
// MCE: compare-exchange unit, routes the larger byte to MAX and the smaller to MIN
//   A, B     : operands
//   MAX, MIN : ordered results (ties give equal values on both)
module MCE
    import median_pkg::*;
(
    input  pix_t A,
    input  pix_t B,
    output pix_t MAX,
    output pix_t MIN
);
    assign MAX = (A > B) ? A : B;
    assign MIN = (A > B) ? B : A;
endmodule

// File: rtl/median_seq.sv
// median_seq: collects nine strobed pixels and extracts their median with one shared MCE
//   CLK  : clock, rising edge
//   nRST : synchronous active-low reset
//   DI   : pixel input, taken when DSI=1 in LOAD
//   DSI  : input strobe
//   DO   : median (register R8), valid while DSO=1
//   DSO  : one-cycle output strobe per frame
module median_seq
    import median_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic [7:0] DI,
    input  logic       DSI,
    output logic [7:0] DO,
    output logic       DSO
);
    state_t     r_state;
    pix_t       r_px [9];
    logic [3:0] r_npix;
    logic [2:0] r_ncmp;
    logic [2:0] r_npass;
    logic       r_dso;
    pix_t       w_max;
    pix_t       w_min;

    MCE u_mce (.A(r_px[8]), .B(r_px[7]), .MAX(w_max), .MIN(w_min));

    assign DO  = r_px[8];
    assign DSO = r_dso;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= LOAD;
            r_npix  <= '0;
            r_ncmp  <= '0;
            r_npass <= '0;
            r_dso   <= 1'b0;
            r_px    <= '{default: '0};
        end else begin
            r_dso <= 1'b0;
            case (r_state)
                LOAD: if (DSI) begin
                    r_px[0] <= DI;
                    for (int i = 1; i < 9; i++) r_px[i] <= r_px[i-1];
                    r_npix <= r_npix + 4'd1;
                    if (r_npix == NPIX - 4'd1) begin
                        r_state <= COMP;
                        r_npix  <= '0;
                        r_ncmp  <= '0;
                        r_npass <= '0;
                    end
                end
                // R8 keeps the running max while R0..R7 rotate past it once
                COMP: begin
                    r_px[8] <= w_max;
                    r_px[0] <= w_min;
                    for (int i = 1; i < 8; i++) r_px[i] <= r_px[i-1];
                    r_ncmp <= r_ncmp + 3'd1;
                    if ({1'b0, r_ncmp} == NCMP - 4'd1) begin
                        r_ncmp <= '0;
                        if (r_npass == NPASS - 3'd1) begin
                            r_state <= OUT;
                            r_dso   <= 1'b1;
                        end else begin
                            r_state <= DROP;
                        end
                    end
                end
                // zero never wins a later compare, so it safely discards the max
                DROP: begin
                    r_px[8] <= '0;
                    r_npass <= r_npass + 3'd1;
                    r_state <= COMP;
                end
                OUT: begin
                    r_state <= LOAD;
                    r_npix  <= '0;
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_median_seq.sv
// tb_median_seq: scoreboard bench for median_seq (value and latency of every DSO pulse)
module tb_median_seq;
    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       DSI = 1'b0;
    logic [7:0] DI = 8'd0;
    logic [7:0] DO;
    logic       DSO;

    median_seq dut (.CLK(CLK), .nRST(nRST), .DI(DI), .DSI(DSI), .DO(DO), .DSO(DSO));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] v;
        int         c;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   npulse = 0;
    int   npush = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] med9(input logic [7:0] p [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = p;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j];
                    s[j] = s[j+1];
                    s[j+1] = t;
                end
        return s[4];
    endfunction

    always @(negedge CLK) begin
        if (DSO === 1'b1) begin
            npulse++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $error("FAIL unexpected_dso at cycle %0d observed DSO=1 expected DSO=0", cyc);
            end else begin
                e_m = q.pop_front();
                assert (DO === e_m.v) else begin
                    bad++;
                    $error("FAIL median_value observed=%0d expected=%0d", DO, e_m.v);
                end
                total++;
                assert (cyc === e_m.c) else begin
                    bad++;
                    $error("FAIL dso_latency observed_cycle=%0d expected_cycle=%0d", cyc, e_m.c);
                end
            end
        end
    end

    task automatic send(input logic [7:0] p [9], input int gpos, input int glen, input bit push);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            DI  = p[i];
            DSI = 1'b1;
            @(posedge CLK);
            #1;
            if (i == gpos) begin
                DSI = 1'b0;
                DI  = 8'($urandom);
                repeat (glen) @(posedge CLK);
                #1;
            end
        end
        DSI = 1'b0;
        if (push) begin
            e.v = med9(p);
            e.c = cyc + 44;
            q.push_back(e);
            npush++;
        end
    endtask

    task automatic idle(input int n, input bit ovr);
        for (int i = 0; i < n; i++) begin
            DSI = ovr;
            DI  = 8'($urandom);
            @(posedge CLK);
            #1;
        end
        DSI = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [7:0] f [9];

    initial begin
        nRST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            DI  = 8'($urandom);
            DSI = 1'($urandom);
            @(posedge CLK);
            #1;
        end
        check("reset_do", DO, 8'd0);
        check("reset_dso", {7'd0, DSO}, 8'd0);
        nRST = 1'b1;
        DSI  = 1'b0;
        idle(60, 1'b0);
        check("reset_no_pulse", 8'(npulse), 8'd0);

        f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send(f, -1, 0, 1'b1);
        idle(45, 1'b0);
        f = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send(f, -1, 0, 1'b1);
        idle(45, 1'b0);
        f = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        send(f, -1, 0, 1'b1);
        idle(45, 1'b0);
        f = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
        send(f, -1, 0, 1'b1);
        idle(45, 1'b0);
        f = '{default: 8'h7F};
        send(f, -1, 0, 1'b1);
        idle(45, 1'b0);

        f = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd5, 8'd2, 8'd8, 8'd6, 8'd4};
        send(f, 3, 3, 1'b1);
        idle(45, 1'b0);

        f = '{8'd20, 8'd90, 8'd40, 8'd70, 8'd10, 8'd60, 8'd30, 8'd80, 8'd50};
        send(f, -1, 0, 1'b1);
        idle(45, 1'b1);

        f = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
        send(f, -1, 0, 1'b0);
        idle(19, 1'b0);
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        check("midreset_do", DO, 8'd0);
        check("midreset_dso", {7'd0, DSO}, 8'd0);
        idle(2, 1'b0);
        f = '{8'd200, 8'd13, 8'd77, 8'd150, 8'd4, 8'd99, 8'd180, 8'd61, 8'd120};
        send(f, -1, 0, 1'b1);
        idle(45, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 9; i++) f[i] = 8'($urandom_range(0, 255));
            send(f, -1, 0, 1'b1);
            idle(45, 1'b0);
        end

        idle(60, 1'b0);
        check("queue_drained", 8'(q.size()), 8'd0);
        total++;
        assert (npulse === npush) else begin
            bad++;
            $error("FAIL pulse_count observed=%0d expected=%0d", npulse, npush);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
